fwd_ctrl: RTL and testbench

- Tracks in-flight destination registers and generates the operand-forwarding selects for the EX-stage 3:1 operand muxes.
- Select encoding per operand: 00 = register-file value, 01 = EX/MEM result, 10 = MEM/WB result.
- Sits between decode/dispatch and EX. Detects load-use hazards and stalls dispatch for one cycle, inserting a bubble.
- Registered outputs line up with the instruction's EX cycle.

---
 rtl/fwd_ctrl_pkg.sv | 24 ++
 rtl/fwd_ctrl_sel_calc.sv | 23 ++
 rtl/fwd_ctrl.sv | 87 ++++++++
 tb/tb_fwd_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_ctrl_pkg.sv
// Shared constants and the stage-record type used by the forwarding controller.
// Select codes drive the EX-stage 3:1 operand muxes.
package fwd_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_RF    = 2'b00;
    localparam logic [SEL_W-1:0] SEL_EXMEM = 2'b01;
    localparam logic [SEL_W-1:0] SEL_MEMWB = 2'b10;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } stage_t;

    // x0 is hardwired to zero, so a write to it never produces a forwardable value.
    function automatic logic live_write(input stage_t s);
        return s.v && s.we && (s.rd != '0);
    endfunction

endpackage

// File: rtl/fwd_ctrl_sel_calc.sv
// Per-operand forwarding select: picks the youngest in-flight producer of rs.
// Purely combinational; instantiated once per source operand.
module fwd_sel_calc
    import fwd_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] i_rs,
    input  stage_t            i_ex,
    input  stage_t            i_mem,
    output logic [SEL_W-1:0]  o_sel
);

    always_comb begin
        o_sel = SEL_RF;
        if (i_rs == '0) begin
            o_sel = SEL_RF;
        end else if (live_write(i_ex) && (i_ex.rd == i_rs)) begin
            o_sel = SEL_EXMEM;
        end else if (live_write(i_mem) && (i_mem.rd == i_rs)) begin
            o_sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding controller: shadows EX/MEM destinations, registers the
// EX-cycle mux selects and stalls dispatch one cycle on a load-use hazard.
module fwd_ctrl
    import fwd_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              hold,
    input  logic              flush,
    output logic              ex_valid,
    output logic [SEL_W-1:0]  fwd_sel_a,
    output logic [SEL_W-1:0]  fwd_sel_b,
    output logic              load_use_stall
);

    stage_t             r_ex;
    stage_t             r_mem;
    logic [SEL_W-1:0]   r_sel_a;
    logic [SEL_W-1:0]   r_sel_b;

    logic               w_hazard;
    logic               w_accept;
    logic [SEL_W-1:0]   w_sel_a;
    logic [SEL_W-1:0]   w_sel_b;
    stage_t             w_id;

    // A load in EX cannot forward to the consumer's EX cycle; the live-write
    // check already excludes rd==x0, so x0 sources never match.
    assign w_hazard = id_valid && live_write(r_ex) && r_ex.ld &&
                      ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

    assign load_use_stall = w_hazard;
    assign id_ready       = !w_hazard && !hold;
    assign w_accept       = id_valid && id_ready && !flush;

    assign w_id.v  = 1'b1;
    assign w_id.rd = id_rd;
    assign w_id.we = id_rd_we;
    assign w_id.ld = id_is_load;

    fwd_sel_calc u_sel_a (
        .i_rs  (id_rs1),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_a)
    );

    fwd_sel_calc u_sel_b (
        .i_rs  (id_rs2),
        .i_ex  (r_ex),
        .i_mem (r_mem),
        .o_sel (w_sel_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex    <= '0;
            r_mem   <= '0;
            r_sel_a <= SEL_RF;
            r_sel_b <= SEL_RF;
        end else if (hold) begin
            r_ex    <= r_ex;
            r_mem   <= r_mem;
            r_sel_a <= r_sel_a;
            r_sel_b <= r_sel_b;
        end else begin
            // On flush w_accept is low, so EX becomes a bubble while the older
            // instruction still advances into MEM.
            r_mem   <= r_ex;
            r_ex    <= w_accept ? w_id : '0;
            r_sel_a <= w_accept ? w_sel_a : SEL_RF;
            r_sel_b <= w_accept ? w_sel_b : SEL_RF;
        end
    end

    assign ex_valid  = r_ex.v;
    assign fwd_sel_a = r_sel_a;
    assign fwd_sel_b = r_sel_b;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Directed bench for fwd_ctrl: in-flight list model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic       id_is_load;
    logic       hold;
    logic       flush;
    logic       ex_valid;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       load_use_stall;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fwd_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_rd_we       (id_rd_we),
        .id_is_load     (id_is_load),
        .hold           (hold),
        .flush          (flush),
        .ex_valid       (ex_valid),
        .fwd_sel_a      (fwd_sel_a),
        .fwd_sel_b      (fwd_sel_b),
        .load_use_stall (load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of in-flight slots, youngest first (index 0 = EX, 1 = MEM).
    typedef struct {
        bit v;
        int rd;
        bit we;
        bit ld;
    } slot_t;

    slot_t pipe[$];
    int    m_ex_valid;
    int    m_sel_a;
    int    m_sel_b;

    // Distance of the youngest writer of rs: 1 -> EX/MEM, 2 -> MEM/WB, 0 -> RF.
    function automatic int m_src(input int rs);
        if (rs == 0) return 0;
        for (int i = 0; i < 2; i++) begin
            if (pipe[i].v && pipe[i].we && pipe[i].rd == rs) return i + 1;
        end
        return 0;
    endfunction

    function automatic bit m_stall();
        return id_valid && pipe[0].v && pipe[0].we && pipe[0].ld && pipe[0].rd != 0 &&
               (pipe[0].rd == int'(id_rs1) || pipe[0].rd == int'(id_rs2));
    endfunction

    always @(posedge clk) begin
        slot_t s;
        bit    acc;
        s = '{v: 1'b0, rd: 0, we: 1'b0, ld: 1'b0};
        if (rst) begin
            pipe = '{s, s};
            m_ex_valid = 0;
            m_sel_a = 0;
            m_sel_b = 0;
        end else if (!hold) begin
            acc = !flush && id_valid && !m_stall();
            if (acc) begin
                m_sel_a = m_src(int'(id_rs1));
                m_sel_b = m_src(int'(id_rs2));
                s = '{v: 1'b1, rd: int'(id_rd), we: id_rd_we, ld: id_is_load};
            end else begin
                m_sel_a = 0;
                m_sel_b = 0;
            end
            m_ex_valid = acc ? 1 : 0;
            pipe.push_front(s);
            void'(pipe.pop_back());
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("m_ex_valid", 32'(ex_valid), 32'(m_ex_valid));
            chk("m_sel_a", 32'(fwd_sel_a), 32'(m_sel_a));
            chk("m_sel_b", 32'(fwd_sel_b), 32'(m_sel_b));
            chk("m_stall", 32'(load_use_stall), 32'(m_stall()));
            chk("m_id_ready", 32'(id_ready), 32'(!m_stall() && !hold));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                          input bit we, input bit ld);
        id_valid   = v;
        id_rs1     = 5'(rs1);
        id_rs2     = 5'(rs2);
        id_rd      = 5'(rd);
        id_rd_we   = we;
        id_is_load = ld;
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0);
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_sel_a", 32'(fwd_sel_a), 0);
        chk("rst_sel_b", 32'(fwd_sel_b), 0);
        chk("rst_stall", 32'(load_use_stall), 0);

        // ADD x5,x1,x2 ; ADD x6,x5,x5
        set_id(1, 1, 2, 5, 1, 0); tick();
        chk("add1_ex_valid", 32'(ex_valid), 1);
        chk("add1_sel_a", 32'(fwd_sel_a), 0);
        set_id(1, 5, 5, 6, 1, 0); #1;
        chk("b2b_stall", 32'(load_use_stall), 0);
        tick();
        chk("b2b_sel_a", 32'(fwd_sel_a), 1);
        chk("b2b_sel_b", 32'(fwd_sel_b), 1);

        // ADD x5 ; NOP ; SUB x7,x5,x1
        set_id(1, 0, 0, 5, 1, 0); tick();
        set_id(0, 0, 0, 0, 0, 0); tick();
        set_id(1, 5, 1, 7, 1, 0); tick();
        chk("gap_sel_a", 32'(fwd_sel_a), 2);
        chk("gap_sel_b", 32'(fwd_sel_b), 0);

        // LW x3 ; ADD x4,x3,x2
        set_id(1, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 2, 4, 1, 0); #1;
        chk("lu_stall", 32'(load_use_stall), 1);
        chk("lu_id_ready", 32'(id_ready), 0);
        tick();
        chk("lu_bubble", 32'(ex_valid), 0);
        chk("lu_stall_gone", 32'(load_use_stall), 0);
        chk("lu_ready_back", 32'(id_ready), 1);
        tick();
        chk("lu_ex_valid", 32'(ex_valid), 1);
        chk("lu_sel_a", 32'(fwd_sel_a), 2);
        chk("lu_sel_b", 32'(fwd_sel_b), 0);

        // Writers to x0 followed by readers of x0
        set_id(1, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 0, 8, 1, 0); #1;
        chk("x0_no_stall", 32'(load_use_stall), 0);
        tick();
        chk("x0_sel_a", 32'(fwd_sel_a), 0);
        chk("x0_sel_b", 32'(fwd_sel_b), 0);

        // ADD x9 ; ADD x9 ; reader of x9
        set_id(1, 0, 0, 9, 1, 0); tick();
        tick();
        set_id(1, 9, 9, 10, 1, 0); tick();
        chk("young_sel_a", 32'(fwd_sel_a), 1);
        chk("young_sel_b", 32'(fwd_sel_b), 1);

        // Flush with a load-use hazard pending
        set_id(1, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 3, 4, 1, 0);
        flush = 1'b1; #1;
        chk("fl_stall_before", 32'(load_use_stall), 1);
        tick();
        flush = 1'b0;
        chk("fl_ex_valid", 32'(ex_valid), 0);
        chk("fl_sel_a", 32'(fwd_sel_a), 0);
        chk("fl_sel_b", 32'(fwd_sel_b), 0);
        chk("fl_stall_after", 32'(load_use_stall), 0);
        tick();
        chk("fl_redo_valid", 32'(ex_valid), 1);
        chk("fl_redo_sel_a", 32'(fwd_sel_a), 2);
        chk("fl_redo_sel_b", 32'(fwd_sel_b), 2);

        // Hold for 3 cycles, then hold with flush, then release
        set_id(1, 4, 0, 12, 1, 0);
        hold = 1'b1; #1;
        chk("hold_id_ready", 32'(id_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ex_valid", 32'(ex_valid), 1);
            chk("hold_sel_a", 32'(fwd_sel_a), 2);
            chk("hold_sel_b", 32'(fwd_sel_b), 2);
        end
        flush = 1'b1; tick();
        chk("hold_flush_ex_valid", 32'(ex_valid), 1);
        chk("hold_flush_sel_a", 32'(fwd_sel_a), 2);
        flush = 1'b0;
        hold = 1'b0; tick();
        chk("hold_rel_sel_a", 32'(fwd_sel_a), 1);
        chk("hold_rel_sel_b", 32'(fwd_sel_b), 0);

        // Hold while a load-use stall is pending
        set_id(1, 0, 0, 3, 1, 1); tick();
        set_id(1, 3, 0, 4, 1, 0);
        hold = 1'b1; #1;
        chk("hstall_on", 32'(load_use_stall), 1);
        tick();
        chk("hstall_kept", 32'(load_use_stall), 1);
        hold = 1'b0; tick();
        chk("hstall_bubble", 32'(ex_valid), 0);
        tick();
        chk("hstall_sel_a", 32'(fwd_sel_a), 2);

        // Reset mid-stream with EX and MEM occupied
        set_id(1, 0, 0, 11, 1, 0); tick();
        set_id(1, 0, 0, 12, 1, 0); tick();
        rst = 1'b1;
        set_id(0, 0, 0, 0, 0, 0); tick();
        rst = 1'b0;
        chk("mrst_ex_valid", 32'(ex_valid), 0);
        chk("mrst_sel_a", 32'(fwd_sel_a), 0);
        chk("mrst_sel_b", 32'(fwd_sel_b), 0);
        set_id(1, 11, 12, 13, 1, 0); tick();
        chk("mrst_reader_valid", 32'(ex_valid), 1);
        chk("mrst_reader_sel_a", 32'(fwd_sel_a), 0);
        chk("mrst_reader_sel_b", 32'(fwd_sel_b), 0);

        set_id(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
